axi_arb2: RTL and testbench
===========================

# axi_arb2

Two-to-one AXI4-Lite arbiter that shares the core's single memory-side AXI master port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Each side gets one whole transaction at a time: an AR+R pair, or an AW+W+B triple.
- Arbitration is round-robin (or fixed LSU priority), with a registered grant.
- Address, data and response signals pass through combinationally once the grant is held.
- The block sits between the IFU/LSU bus masters and the interconnect bridge.

## Interface
Parameters:
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = LSU always wins ties
- ADDR_W, 32, address width of all ar/aw channels
- DATA_W, 32, data width of r/w channels; wstrb is DATA_W/8

Ports:
- clk_i  input  1  core clock; all state updates on rising edge
- rst_i  input  1  synchronous reset, active-high (rst_i == `ysyx_23060251_rst_enable`)
- ifu_s  axi_if.Slave  bundle  IFU request port; only AR/R used
- lsu_s  axi_if.Slave  bundle  LSU request port; AR/R/AW/W/B all used
- mem_m  axi_if.Master  bundle  shared downstream port toward the interconnect

## Operation
- States: IDLE, RD_IFU, RD_LSU, WR_LSU.
- Registers:
  - state
  - last (last granted: 0 = IFU, 1 = LSU)
  - ar_done, aw_done, w_done (per-grant address/data phase flags)
- IDLE request evaluation:
  - req_ifu = ifu_s.arvalid.
  - req_lsu_rd = lsu_s.arvalid.
  - req_lsu_wr = lsu_s.awvalid | lsu_s.wvalid.
  - LSU internal order: if both req_lsu_rd and req_lsu_wr, the read is chosen.
- Tie between IFU and LSU:
  - RR_EN=1: grant the side not equal to last.
  - RR_EN=0: LSU wins.
- Single requester: it wins immediately. No request: stay IDLE.
- RD_x: mem_m AR is driven from the granted slave's AR; granted arready = mem_m.arready.
  - On AR handshake, set ar_done. While ar_done=1, mem_m.arvalid is forced 0.
  - mem_m R is forwarded to the granted slave; mem_m.rready = granted rready.
  - On R handshake (rvalid & rready): go to IDLE, last <= granted side, clear flags.
- WR_LSU: AW and W are forwarded independently.
  - Each handshake sets aw_done / w_done; the corresponding valid toward mem_m is forced 0 afterwards.
  - B is forwarded to lsu_s. On B handshake: go to IDLE, last <= 1, clear flags.
  - A B handshake before both aw_done and w_done is a downstream protocol error. The arbiter still returns to IDLE.
- Non-granted slave and idle cycles:
  - All of its readies (arready, awready, wready) are 0.
  - Its rvalid and bvalid are 0.
- IFU write channels: awready, wready and bvalid are permanently 0. IFU aw/w valids are ignored.
- In IDLE, all mem_m valids and readies are 0.
- rresp/bresp and rdata pass through unmodified. Error responses do not alter arbitration.
- Requesters must hold valid and payload stable until handshake (AXI rule). The arbiter does not latch payloads.

## Timing
- Reset: state=IDLE, last=1 (so IFU wins the first tie, for boot fetch), all flags 0.
- During and after reset until grant, these outputs are 0:
  - mem_m.arvalid/awvalid/wvalid/rready/bready
  - ifu_s/lsu_s arready/awready/wready/rvalid/bvalid
- Arbitration latency: a request seen in IDLE at cycle N is granted at N+1; mem_m.arvalid/awvalid rises at N+1 (earliest slave ready is also N+1).
- Turnaround: final handshake at T leads to IDLE at T+1 and the next grant at T+2. Minimum back-to-back spacing is one idle cycle.
- Pass-through paths (ready/valid/data) are combinational in a grant state: zero added latency per beat.
- A request arriving while another grant is active waits; it is never dropped while its valid stays high.
- Reset mid-transaction returns to IDLE next edge. The outstanding downstream transaction is abandoned; the interconnect must also be reset.
- Starvation bound (RR_EN=1): a continuously requesting side waits at most one foreign transaction.

## Test plan
- Single IFU read: ifu arvalid at cycle 2, addr 0x8000_0000, mem arready at 3, rvalid at 5 with rdata 0xDEAD_BEEF. Required:
  - mem arvalid is high in cycle 3 only.
  - ifu rvalid=1 with 0xDEAD_BEEF at 5.
  - IDLE at 6.
- Simultaneous IFU and LSU read from reset (RR_EN=1): IFU is granted first. LSU is granted two cycles after the IFU R handshake. A second tie then goes to IFU only if LSU was last.
- Same simultaneous stimulus with RR_EN=0: LSU is granted every tie. The IFU is serviced only in cycles where the LSU has no request.
- LSU write with W before AW: wvalid at 2, awvalid at 4, bvalid at 6. Required:
  - w_done=1 after cycle 3's handshake (arbiter grant at 3).
  - mem wvalid is 0 afterwards while awvalid stays forwarded.
  - lsu bvalid=1 at 6; IFU arvalid waiting since 3 is granted at 8.
- LSU arvalid+awvalid together: the read completes first, then the write is granted two cycles after R handshake. IFU aw/w valids forced high throughout get no awready/wready/bvalid.
- rst_i pulsed during RD_LSU with mem rvalid pending:
  - Next cycle: state IDLE, all valids/readies 0, last=1.
  - A subsequent IFU request is granted normally.

Source files
------------

// File: rtl/axi_arb2_if.sv
// axi_if: AXI4-Lite bundle with master/slave views
interface axi_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [ADDR_W-1:0]   araddr, awaddr;
  logic [DATA_W-1:0]   rdata, wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [1:0]          rresp, bresp;
  logic arvalid, arready, rvalid, rready;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  modport Master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport Slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_arb2.sv
// axi_arb2: whole-transaction IFU/LSU arbiter onto one AXI4-Lite master port
module axi_arb2 #(
  parameter bit RR_EN  = 1'b1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic   clk_i,
  input logic   rst_i,
  axi_if.Slave  ifu_s,
  axi_if.Slave  lsu_s,
  axi_if.Master mem_m
);
  typedef enum logic [1:0] {IDLE, RD_IFU, RD_LSU, WR_LSU} state_t;
  state_t state, state_nx;
  logic last, ar_done, aw_done, w_done;
  logic rd_ifu, rd_lsu, wr_lsu, req_ifu, req_lsu, pick_lsu, fin;
  assign rd_ifu   = state == RD_IFU;
  assign rd_lsu   = state == RD_LSU;
  assign wr_lsu   = state == WR_LSU;
  assign req_ifu  = ifu_s.arvalid;
  assign req_lsu  = lsu_s.arvalid | lsu_s.awvalid | lsu_s.wvalid;
  assign pick_lsu = req_lsu & (!req_ifu | (RR_EN == 1'b0) | !last);
  assign fin      = ((rd_ifu | rd_lsu) & mem_m.rvalid & mem_m.rready) | (wr_lsu & mem_m.bvalid & mem_m.bready);
  // next grant: arbitrate in IDLE, hold the grant until the final handshake
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (!(req_ifu | req_lsu) ? IDLE : !pick_lsu ? RD_IFU : lsu_s.arvalid ? RD_LSU : WR_LSU)
             : fin ? IDLE : state;
  end
  // grant, fairness pointer and per-grant phase flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      last    <= 1'b1;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nx;
      if (fin) begin
        last    <= !rd_ifu;
        ar_done <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (mem_m.arvalid & mem_m.arready) ar_done <= 1'b1;
        if (mem_m.awvalid & mem_m.awready) aw_done <= 1'b1;
        if (mem_m.wvalid & mem_m.wready) w_done <= 1'b1;
      end
    end
  end
  assign mem_m.araddr  = rd_lsu ? lsu_s.araddr : ifu_s.araddr;
  assign mem_m.arvalid = !ar_done & ((rd_ifu & ifu_s.arvalid) | (rd_lsu & lsu_s.arvalid));
  assign ifu_s.arready = rd_ifu & !ar_done & mem_m.arready;
  assign lsu_s.arready = rd_lsu & !ar_done & mem_m.arready;
  assign mem_m.rready  = (rd_ifu & ifu_s.rready) | (rd_lsu & lsu_s.rready);
  assign ifu_s.rvalid  = rd_ifu & mem_m.rvalid;
  assign lsu_s.rvalid  = rd_lsu & mem_m.rvalid;
  assign ifu_s.rdata   = mem_m.rdata;
  assign lsu_s.rdata   = mem_m.rdata;
  assign ifu_s.rresp   = mem_m.rresp;
  assign lsu_s.rresp   = mem_m.rresp;
  assign mem_m.awaddr  = lsu_s.awaddr;
  assign mem_m.awvalid = wr_lsu & !aw_done & lsu_s.awvalid;
  assign lsu_s.awready = wr_lsu & !aw_done & mem_m.awready;
  assign mem_m.wdata   = lsu_s.wdata;
  assign mem_m.wstrb   = lsu_s.wstrb;
  assign mem_m.wvalid  = wr_lsu & !w_done & lsu_s.wvalid;
  assign lsu_s.wready  = wr_lsu & !w_done & mem_m.wready;
  assign mem_m.bready  = wr_lsu & lsu_s.bready;
  assign lsu_s.bvalid  = wr_lsu & mem_m.bvalid;
  assign lsu_s.bresp   = mem_m.bresp;
  assign ifu_s.awready = 1'b0;
  assign ifu_s.wready  = 1'b0;
  assign ifu_s.bvalid  = 1'b0;
  assign ifu_s.bresp   = '0;
endmodule

// File: tb/tb_axi_arb2.sv
// tb_axi_arb2: directed checks of axi_arb2 grant order, forwarding and reset
module tb_axi_arb2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  axi_if #(32, 32) ifu0 (), lsu0 (), mem0 (), ifu1 (), lsu1 (), mem1 ();
  axi_arb2 #(.RR_EN(1'b1)) dut0 (.clk_i(clk), .rst_i(rst), .ifu_s(ifu0), .lsu_s(lsu0), .mem_m(mem0));
  axi_arb2 #(.RR_EN(1'b0)) dut1 (.clk_i(clk), .rst_i(rst), .ifu_s(ifu1), .lsu_s(lsu1), .mem_m(mem1));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [11:0] quiet0();
    return {mem0.arvalid, mem0.awvalid, mem0.wvalid, mem0.rready, mem0.bready, ifu0.arready,
            lsu0.arready, lsu0.awready, lsu0.wready, ifu0.rvalid, lsu0.rvalid, lsu0.bvalid};
  endfunction
  task automatic clr();
    {ifu0.araddr, ifu0.arvalid, ifu0.rready, ifu0.awaddr, ifu0.awvalid, ifu0.wdata, ifu0.wstrb, ifu0.wvalid, ifu0.bready} = '0;
    {lsu0.araddr, lsu0.arvalid, lsu0.rready, lsu0.awaddr, lsu0.awvalid, lsu0.wdata, lsu0.wstrb, lsu0.wvalid, lsu0.bready} = '0;
    {mem0.arready, mem0.rdata, mem0.rresp, mem0.rvalid, mem0.awready, mem0.wready, mem0.bresp, mem0.bvalid} = '0;
    {ifu1.araddr, ifu1.arvalid, ifu1.rready, ifu1.awaddr, ifu1.awvalid, ifu1.wdata, ifu1.wstrb, ifu1.wvalid, ifu1.bready} = '0;
    {lsu1.araddr, lsu1.arvalid, lsu1.rready, lsu1.awaddr, lsu1.awvalid, lsu1.wdata, lsu1.wstrb, lsu1.wvalid, lsu1.bready} = '0;
    {mem1.arready, mem1.rdata, mem1.rresp, mem1.rvalid, mem1.awready, mem1.wready, mem1.bresp, mem1.bvalid} = '0;
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    clr();
    cyc();
    rst = 1'b0;
  endtask
  task automatic finish_read(input bit side);
    logic [31:0] d;
    d = 32'h5a5a_0000 | 32'(side);
    mem0.arready = 1'b1;
    #1;
    check("rd_arready_granted", side ? lsu0.arready : ifu0.arready, 1);
    check("rd_arready_other", side ? ifu0.arready : lsu0.arready, 0);
    cyc();
    mem0.arready = 1'b0;
    if (side) lsu0.arvalid = 1'b0;
    else ifu0.arvalid = 1'b0;
    mem0.rvalid = 1'b1;
    mem0.rdata = d;
    ifu0.rready = 1'b1;
    lsu0.rready = 1'b1;
    #1;
    check("rd_rvalid_ifu", ifu0.rvalid, !side);
    check("rd_rvalid_lsu", lsu0.rvalid, side);
    check("rd_rdata", side ? lsu0.rdata : ifu0.rdata, d);
    cyc();
    mem0.rvalid = 1'b0;
    ifu0.rready = 1'b0;
    lsu0.rready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    clr();
    cyc();
    check("rst_quiet_during", 32'(quiet0()), 0);
    cyc();
    rst = 1'b0;
    #1;
    check("rst_state", 32'(dut0.state), 0);
    check("rst_last", dut0.last, 1);
    check("rst_quiet_after", 32'(quiet0()), 0);
    // single IFU read
    ifu0.arvalid = 1'b1;
    ifu0.araddr = 32'h8000_0000;
    #1 check("t1_idle_arvalid", mem0.arvalid, 0);
    cyc();
    mem0.arready = 1'b1;
    #1;
    check("t1_grant", 32'(dut0.state), 1);
    check("t1_arvalid", mem0.arvalid, 1);
    check("t1_araddr", mem0.araddr, 32'h8000_0000);
    check("t1_arready", ifu0.arready, 1);
    cyc();
    mem0.arready = 1'b0;
    #1 check("t1_arvalid_forced0", mem0.arvalid, 0);
    ifu0.arvalid = 1'b0;
    cyc();
    mem0.rvalid = 1'b1;
    mem0.rdata = 32'hDEAD_BEEF;
    ifu0.rready = 1'b1;
    #1;
    check("t1_rvalid", ifu0.rvalid, 1);
    check("t1_rdata", ifu0.rdata, 32'hDEAD_BEEF);
    check("t1_rready", mem0.rready, 1);
    check("t1_lsu_rvalid", lsu0.rvalid, 0);
    cyc();
    mem0.rvalid = 1'b0;
    ifu0.rready = 1'b0;
    #1;
    check("t1_idle", 32'(dut0.state), 0);
    check("t1_last", dut0.last, 0);
    // simultaneous reads, round-robin
    reset_dut();
    ifu0.arvalid = 1'b1;
    ifu0.araddr = 32'h1000;
    lsu0.arvalid = 1'b1;
    lsu0.araddr = 32'h2000;
    cyc();
    #1;
    check("t2_first_ifu", 32'(dut0.state), 1);
    check("t2_araddr_ifu", mem0.araddr, 32'h1000);
    finish_read(1'b0);
    #1;
    check("t2_turnaround_idle", 32'(dut0.state), 0);
    check("t2_idle_arvalid", mem0.arvalid, 0);
    cyc();
    #1;
    check("t2_then_lsu", 32'(dut0.state), 2);
    check("t2_araddr_lsu", mem0.araddr, 32'h2000);
    ifu0.arvalid = 1'b1;
    finish_read(1'b1);
    lsu0.arvalid = 1'b1;
    cyc();
    #1 check("t2_second_tie_ifu", 32'(dut0.state), 1);
    // simultaneous reads, fixed LSU priority
    reset_dut();
    ifu1.arvalid = 1'b1;
    lsu1.arvalid = 1'b1;
    cyc();
    #1;
    check("t3_tie_lsu", 32'(dut1.state), 2);
    check("t3_ifu_arready", ifu1.arready, 0);
    mem1.arready = 1'b1;
    cyc();
    mem1.arready = 1'b0;
    mem1.rvalid = 1'b1;
    lsu1.rready = 1'b1;
    cyc();
    mem1.rvalid = 1'b0;
    #1 check("t3_idle", 32'(dut1.state), 0);
    cyc();
    #1;
    check("t3_tie2_lsu", 32'(dut1.state), 2);
    check("t3_last", dut1.last, 1);
    lsu1.arvalid = 1'b0;
    mem1.arready = 1'b1;
    cyc();
    mem1.arready = 1'b0;
    mem1.rvalid = 1'b1;
    cyc();
    mem1.rvalid = 1'b0;
    cyc();
    #1 check("t3_ifu_alone", 32'(dut1.state), 1);
    // LSU write with W ahead of AW
    reset_dut();
    lsu0.wvalid = 1'b1;
    lsu0.wdata = 32'hCAFE_0001;
    lsu0.wstrb = 4'hF;
    #1 check("t4_idle_wvalid", mem0.wvalid, 0);
    cyc();
    ifu0.arvalid = 1'b1;
    mem0.wready = 1'b1;
    #1;
    check("t4_grant_wr", 32'(dut0.state), 3);
    check("t4_wvalid", mem0.wvalid, 1);
    check("t4_wdata", mem0.wdata, 32'hCAFE_0001);
    check("t4_wready", lsu0.wready, 1);
    check("t4_ifu_arready", ifu0.arready, 0);
    cyc();
    mem0.wready = 1'b0;
    #1;
    check("t4_w_done", dut0.w_done, 1);
    check("t4_wvalid_forced0", mem0.wvalid, 0);
    lsu0.awvalid = 1'b1;
    lsu0.awaddr = 32'h3000;
    mem0.awready = 1'b1;
    #1;
    check("t4_awvalid", mem0.awvalid, 1);
    check("t4_awaddr", mem0.awaddr, 32'h3000);
    check("t4_awready", lsu0.awready, 1);
    cyc();
    mem0.awready = 1'b0;
    #1;
    check("t4_awvalid_forced0", mem0.awvalid, 0);
    check("t4_aw_done", dut0.aw_done, 1);
    lsu0.awvalid = 1'b0;
    lsu0.wvalid = 1'b0;
    cyc();
    mem0.bvalid = 1'b1;
    mem0.bresp = 2'd2;
    lsu0.bready = 1'b1;
    #1;
    check("t4_bvalid", lsu0.bvalid, 1);
    check("t4_bresp", lsu0.bresp, 2);
    check("t4_bready", mem0.bready, 1);
    check("t4_ifu_wait", ifu0.arready, 0);
    cyc();
    mem0.bvalid = 1'b0;
    lsu0.bready = 1'b0;
    #1;
    check("t4_idle", 32'(dut0.state), 0);
    check("t4_last", dut0.last, 1);
    check("t4_w_done_clr", dut0.w_done, 0);
    cyc();
    #1;
    check("t4_ifu_granted", 32'(dut0.state), 1);
    check("t4_ifu_arvalid", mem0.arvalid, 1);
    // LSU read+write together, IFU write valids ignored
    reset_dut();
    ifu0.awvalid = 1'b1;
    ifu0.wvalid = 1'b1;
    lsu0.arvalid = 1'b1;
    lsu0.awvalid = 1'b1;
    lsu0.wvalid = 1'b1;
    cyc();
    #1;
    check("t5_read_first", 32'(dut0.state), 2);
    check("t5_awvalid_rd", mem0.awvalid, 0);
    finish_read(1'b1);
    #1 check("t5_idle", 32'(dut0.state), 0);
    cyc();
    #1;
    check("t5_write", 32'(dut0.state), 3);
    check("t5_awvalid", mem0.awvalid, 1);
    check("t5_wvalid", mem0.wvalid, 1);
    mem0.awready = 1'b1;
    mem0.wready = 1'b1;
    #1;
    check("t5_ifu_awready", ifu0.awready, 0);
    check("t5_ifu_wready", ifu0.wready, 0);
    check("t5_lsu_awready", lsu0.awready, 1);
    cyc();
    mem0.awready = 1'b0;
    mem0.wready = 1'b0;
    lsu0.awvalid = 1'b0;
    lsu0.wvalid = 1'b0;
    mem0.bvalid = 1'b1;
    lsu0.bready = 1'b1;
    #1;
    check("t5_lsu_bvalid", lsu0.bvalid, 1);
    check("t5_ifu_bvalid", ifu0.bvalid, 0);
    cyc();
    mem0.bvalid = 1'b0;
    #1 check("t5_done", 32'(dut0.state), 0);
    // reset in the middle of an LSU read
    reset_dut();
    ifu0.arvalid = 1'b1;
    cyc();
    finish_read(1'b0);
    lsu0.arvalid = 1'b1;
    lsu0.araddr = 32'h4000;
    cyc();
    #1;
    check("t6_rd_lsu", 32'(dut0.state), 2);
    check("t6_last_ifu", dut0.last, 0);
    mem0.arready = 1'b1;
    cyc();
    mem0.arready = 1'b0;
    lsu0.arvalid = 1'b0;
    mem0.rvalid = 1'b1;
    lsu0.rready = 1'b1;
    rst = 1'b1;
    #1 check("t6_rvalid_pending", lsu0.rvalid, 1);
    cyc();
    rst = 1'b0;
    #1;
    check("t6_idle", 32'(dut0.state), 0);
    check("t6_last", dut0.last, 1);
    check("t6_quiet", 32'(quiet0()), 0);
    mem0.rvalid = 1'b0;
    lsu0.rready = 1'b0;
    ifu0.arvalid = 1'b1;
    cyc();
    #1;
    check("t6_regrant", 32'(dut0.state), 1);
    check("t6_arvalid", mem0.arvalid, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
